// File: rtl/mlbmp_fetch.sv
`default_nettype none
// ============================================================================
// Module      : mlbmp_fetch
// Description : VRAM byte prefetcher for the 320x240 monochrome bitmap mode.
//               Every bitmap pixel covers 2x2 screen pixels, so one bitmap
//               byte spans 16 screen columns. Once per scanline the row's
//               bitmap bytes are read through a req/gnt + in-order rvalid
//               memory port into a small FIFO, whose head is presented on
//               val for the 16 screen clocks that byte covers.
//
// Ports       : clk         pixel clock
//               rst_n       synchronous reset, active low
//               line_start  1-clk pulse: start fetching the upcoming line
//               line_y      screen row of the upcoming line (9b)
//               posx        current screen column (10b)
//               mem_req     read request, held with mem_addr until mem_gnt
//               mem_addr    {row[7:0], 2'b00, byte[5:0]}
//               mem_gnt     request accepted this clk
//               mem_rvalid  read data valid (in request order)
//               mem_rdata   read data (8b)
//               val         FIFO head byte, 8'h00 when empty
//               underrun    sticky: a pop was required while empty
//               fifo_level  current FIFO occupancy 0..DEPTH
//
// Revision    : 1.0  initial release
// ============================================================================
module mlbmp_fetch #(
    parameter int H_ACTIVE      = 640,
    parameter int BYTES_PER_ROW = 40,
    parameter int DEPTH         = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        line_start,
    input  logic [8:0]  line_y,
    input  logic [9:0]  posx,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  val,
    output logic        underrun,
    output logic [2:0]  fifo_level
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int              c_ptr_w     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ptr_w-1:0] c_ptr_one = 1;
    localparam logic [2:0]      c_depth_lvl = 3'(DEPTH);
    localparam logic [5:0]      c_last_byte = 6'(BYTES_PER_ROW - 1);
    localparam logic [9:0]      c_h_active  = 10'(H_ACTIVE);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_fetch = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;

    logic [7:0]         r_row;        // bitmap row = line_y[8:1]
    logic [5:0]         r_byte;       // next byte index to request
    logic [2:0]         r_out;        // granted reads of this line not yet returned
    logic [7:0]         r_discard;    // returns still owed to abandoned lines
    logic               r_restart;    // clk right after line_start

    logic [7:0]         r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [2:0]         r_level;
    logic               r_underrun;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic w_gnt;
    logic w_last_byte;
    logic w_credit;
    logic w_pop;
    logic w_empty;
    logic w_full;
    logic w_pop_ok;
    logic w_ret_drop;
    logic w_ret_live;
    logic w_push;
    logic w_unused_ly0;

    // Only the upper 8 bits of the screen row select a bitmap row.
    assign w_unused_ly0 = line_y[0];

    assign w_empty     = (r_level == 3'd0);
    assign w_full      = (r_level == c_depth_lvl);
    assign w_last_byte = (r_byte == c_last_byte);

    // Credit counts FIFO entries plus reads already in flight for this
    // line, so every granted read is guaranteed a slot when it returns.
    assign w_credit = ({1'b0, r_level} + {1'b0, r_out}) < {1'b0, c_depth_lvl};

    // The request is withheld for the clk following line_start so that a
    // request left over from the previous line is withdrawn before the
    // first byte of the new row is asked for.
    assign mem_req  = (r_state == c_st_fetch) && !r_restart && w_credit;
    assign mem_addr = {r_row, 2'b00, r_byte};
    assign w_gnt    = mem_req && mem_gnt;

    // Pop on the last column of each 16-column byte slot, so the next head
    // appears exactly on the following byte boundary.
    assign w_pop    = (posx < c_h_active) && (posx[3:0] == 4'hF);
    assign w_pop_ok = w_pop && !w_empty;

    // Returns are strictly in order: owed returns of abandoned lines are
    // consumed first, anything after that belongs to the current line.
    assign w_ret_drop = mem_rvalid && (r_discard != 8'd0);
    assign w_ret_live = mem_rvalid && !w_ret_drop;
    // Data arriving with line_start belongs to the line being abandoned.
    assign w_push     = w_ret_live && !line_start;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (line_start) begin
                    w_state_nxt = c_st_fetch;
                end
            end
            c_st_fetch: begin
                if (line_start) begin
                    w_state_nxt = c_st_fetch;
                end else if (w_gnt && w_last_byte) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: begin
                if (line_start) begin
                    w_state_nxt = c_st_fetch;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Counters and FIFO control
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_row      <= 8'd0;
            r_byte     <= 6'd0;
            r_out      <= 3'd0;
            r_discard  <= 8'd0;
            r_restart  <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_level    <= 3'd0;
            r_underrun <= 1'b0;
        end else begin
            r_restart <= line_start;

            if (w_pop && w_empty) begin
                r_underrun <= 1'b1;
            end

            if (line_start) begin
                r_row    <= line_y[8:1];
                r_byte   <= 6'd0;
                r_out    <= 3'd0;
                // Everything still in flight for the old line, including a
                // grant taken this clk, is owed as a discard; a return in
                // this same clk has already been paid off.
                r_discard <= r_discard + 8'(r_out) + 8'(w_gnt) - 8'(mem_rvalid);
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_level  <= 3'd0;
            end else begin
                // The counter parks on the last byte once it is granted.
                if (w_gnt && !w_last_byte) begin
                    r_byte <= r_byte + 6'd1;
                end
                r_out <= r_out + 3'(w_gnt) - 3'(w_ret_live);
                if (w_ret_drop) begin
                    r_discard <= r_discard - 8'd1;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_ptr_one;
                end
                if (w_pop_ok) begin
                    r_rd_ptr <= r_rd_ptr + c_ptr_one;
                end
                // A pop of an empty FIFO takes nothing, so a byte pushed in
                // that same clk is kept as the new head.
                r_level <= r_level + 3'(w_push) - 3'(w_pop_ok);
            end
        end
    end

    // FIFO storage carries no reset; emptiness is tracked by r_level.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= mem_rdata;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign val        = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign underrun   = r_underrun;
    assign fifo_level = r_level;

    // ------------------------------------------------------------------------
    // Design checks
    // ------------------------------------------------------------------------
    a_no_push_full : assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && w_full && !w_pop));

    a_credit_bound : assert property (@(posedge clk) disable iff (!rst_n)
        ({1'b0, r_level} + {1'b0, r_out}) <= {1'b0, c_depth_lvl});

endmodule

`default_nettype wire

// File: tb/tb_mlbmp_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_mlbmp_fetch
// Description : Self-checking bench for mlbmp_fetch. A behavioural model
//               tracks the byte queue, the lines reads belong to and the
//               fetch progress of each line, and a memory model answers
//               grants in order with randomized latency.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mlbmp_fetch;

    localparam int c_depth   = 4;
    localparam int c_nbytes  = 40;
    localparam int c_h_act   = 640;
    localparam int c_h_total = 800;
    localparam int c_ls_pos  = 720;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        line_start;
    logic [8:0]  line_y;
    logic [9:0]  posx;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [7:0]  mem_rdata;
    logic [7:0]  val;
    logic        underrun;
    logic [2:0]  fifo_level;

    always #5 clk = ~clk;

    mlbmp_fetch #(
        .H_ACTIVE      (c_h_act),
        .BYTES_PER_ROW (c_nbytes),
        .DEPTH         (c_depth)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .line_start (line_start),
        .line_y     (line_y),
        .posx       (posx),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .val        (val),
        .underrun   (underrun),
        .fifo_level (fifo_level)
    );

    // ------------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------------
    typedef struct {
        int         tag;     // line the read was granted for
        logic [7:0] data;
        int         ready;   // first cycle the data may return
    } rd_t;

    rd_t        mem_q[$];
    logic [7:0] fifo_q[$];

    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         px = 700;
    int         cur_line = 0;
    int         exp_byte = 0;
    int         last_ready = 0;
    bit         active = 1'b0;
    bit         restart = 1'b0;
    bit         m_underrun = 1'b0;
    bit         chk_en = 1'b0;
    bit         gnt_block = 1'b0;
    logic [7:0] cur_row = 8'd0;

    // Stimulus knobs
    int         lat_min = 1;
    int         lat_max = 1;
    int         gnt_pct = 100;
    int         extra_ls = -1;
    int         reset_at = -1;
    bit         idx_data = 1'b0;
    bit         block_mode = 1'b0;
    logic [8:0] next_ly = 9'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d, posx %0d)",
                     tag, got, exp, cyc, px);
        end
    endtask

    function automatic int inflight_cur();
        int n = 0;
        foreach (mem_q[i]) begin
            if (mem_q[i].tag == cur_line) n++;
        end
        return n;
    endfunction

    // One pixel clock: check the state reached at the last edge, drive the
    // inputs for the coming edge, then advance the model across that edge.
    task automatic step(input bit do_rst);
        bit         exp_req;
        bit         pop;
        rd_t        r;
        int         lat;
        @(negedge clk);
        if (chk_en) begin
            exp_req = active && (exp_byte < c_nbytes) && !restart &&
                      ((fifo_q.size() + inflight_cur()) < c_depth);
            chk("mem_req", mem_req, exp_req);
            if (exp_req) chk("mem_addr", mem_addr, {cur_row, 2'b00, 6'(exp_byte)});
            chk("val", val, (fifo_q.size() != 0) ? fifo_q[0] : 8'h00);
            chk("fifo_level", fifo_level, fifo_q.size());
            chk("underrun", underrun, m_underrun);
        end

        posx = 10'(px);
        if (do_rst) begin
            rst_n      = 1'b0;
            line_start = 1'b0;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = 8'h00;
        end else begin
            rst_n      = 1'b1;
            line_start = (px == c_ls_pos) || (px == extra_ls);
            if (line_start) line_y = (px == c_ls_pos) ? next_ly : 9'($urandom_range(0, 479));
            if (line_start && (px == c_ls_pos) && block_mode) gnt_block = 1'b1;
            if (px == 20) gnt_block = 1'b0;
            mem_gnt    = !gnt_block && ($urandom_range(0, 99) < gnt_pct);
            mem_rvalid = 1'b0;
            mem_rdata  = 8'($urandom);
            if (mem_q.size() != 0 && mem_q[0].ready <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_q[0].data;
            end
        end

        if (do_rst) begin
            fifo_q.delete();
            mem_q.delete();
            active     = 1'b0;
            restart    = 1'b0;
            m_underrun = 1'b0;
            exp_byte   = 0;
            cur_row    = 8'd0;
            last_ready = 0;
            gnt_block  = 1'b0;
        end else begin
            if (mem_req && mem_gnt) begin
                lat = $urandom_range(lat_min, lat_max);
                if (cyc + lat > last_ready) last_ready = cyc + lat;
                r.tag   = cur_line;
                r.data  = idx_data ? 8'(exp_byte) : 8'($urandom);
                r.ready = last_ready;
                mem_q.push_back(r);
                exp_byte++;
            end
            pop = (px < c_h_act) && (px % 16 == 15);
            if (pop) begin
                if (fifo_q.size() != 0) void'(fifo_q.pop_front());
                else m_underrun = 1'b1;
            end
            if (mem_rvalid) begin
                r = mem_q.pop_front();
                if (!line_start && r.tag == cur_line) fifo_q.push_back(r.data);
            end
            if (line_start) begin
                fifo_q.delete();
                cur_line++;
                active   = 1'b1;
                exp_byte = 0;
                cur_row  = line_y[8:1];
            end
            restart = line_start;
        end
        chk_en = 1'b1;
        px = (px + 1) % c_h_total;
        cyc++;
    endtask

    // Runs from wherever posx is up to the next line_start, then one whole
    // line period, ending just before the following line_start.
    task automatic run_line();
        while (px != c_ls_pos) step(1'b0);
        for (int i = 0; i < c_h_total; i++) step(px == reset_at);
    endtask

    initial begin
        rst_n      = 1'b0;
        line_start = 1'b0;
        line_y     = 9'd0;
        posx       = 10'd0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 8'h00;

        step(1'b1);
        step(1'b1);

        // Row 5 (line_y=10), zero-wait grant, 1-clk return, data = byte index.
        next_ly  = 9'd10;
        idx_data = 1'b1;
        lat_min  = 1;
        lat_max  = 1;
        gnt_pct  = 100;
        run_line();
        idx_data = 1'b0;

        // Random rows, latencies and grant rates.
        for (int n = 0; n < 4; n++) begin
            next_ly = 9'($urandom_range(0, 479));
            lat_min = 1;
            lat_max = 6;
            gnt_pct = $urandom_range(50, 100);
            run_line();
        end

        // Second line_start while reads are still outstanding.
        next_ly  = 9'($urandom_range(0, 479));
        lat_min  = 5;
        lat_max  = 5;
        gnt_pct  = 100;
        extra_ls = 725;
        run_line();

        // Second line_start coinciding with a grant and a return.
        next_ly  = 9'($urandom_range(0, 479));
        lat_min  = 1;
        lat_max  = 1;
        run_line();
        extra_ls = -1;

        // Grants held off until posx=20: the first pop underruns.
        next_ly    = 9'($urandom_range(0, 479));
        lat_max    = 3;
        block_mode = 1'b1;
        run_line();
        block_mode = 1'b0;

        // Reset mid-line, then a normal line afterwards.
        next_ly  = 9'($urandom_range(0, 479));
        reset_at = 300;
        run_line();
        reset_at = -1;
        next_ly  = 9'($urandom_range(0, 479));
        run_line();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
